// File: rtl/hazard_pkg.sv
// Shared types and constants for the parametrised pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {RUN, DWAIT, LUSTALL, HALTED} hz_state_t;

  localparam int IFID    = 0;
  localparam int IDEX    = 1;
  localparam int EXMEM   = 2;
  localparam int MEMWB   = 3;
  localparam int PCW_DEF = 32;

endpackage

// File: rtl/hz_lu_detect.sv
// Load-use compare: a load in ID/EX whose destination is read by the instruction in IF/ID.
module hz_lu_detect #(
  parameter int REGW = 5
) (
  input  logic            ex_memread,
  input  logic [REGW-1:0] ex_rd,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  output logic            hazard
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = ex_memread && (ex_rd != '0) &&
                  ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

endmodule

// File: rtl/hazard_ctrl_n.sv
// Pipeline hazard controller: per-stage write-enable/flush, load-use stall sequencing,
// sticky halt and a saturating stall-cycle counter.
//
// state   | meaning
// RUN     | normal flow, single-cycle hazards only
// DWAIT   | data access outstanding, stages upstream of MEM frozen
// LUSTALL | extra load-use bubble cycles still to insert
// HALTED  | halt retired, pipeline frozen until reset
module hazard_ctrl_n
  import hazard_pkg::*;
#(
  parameter int NSTAGES  = 5,
  parameter int MEM_IDX  = MEMWB,
  parameter int REGW     = 5,
  parameter int LU_STALL = 1,
  parameter int PCW      = PCW_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ihit,
  input  logic                       dhit,
  input  logic                       dREN,
  input  logic                       dWEN,
  input  logic                       redirect,
  input  logic [$clog2(NSTAGES)-1:0] redirect_stg,
  input  logic                       halt_req,
  input  logic                       ex_memread,
  input  logic [REGW-1:0]            ex_rd,
  input  logic [REGW-1:0]            id_rs,
  input  logic [REGW-1:0]            id_rt,
  input  logic                       id_use_rs,
  input  logic                       id_use_rt,
  output logic [NSTAGES-1:0]         stage_wen,
  output logic [NSTAGES-1:0]         stage_flush,
  output logic                       halted,
  output logic [1:0]                 state,
  output logic [PCW-1:0]             stall_cnt
);

  localparam int LUCW = 3;

  hz_state_t       state_q, state_d;
  logic [LUCW-1:0] lu_q, lu_d;
  logic            lu_hit;
  logic            mem_miss;

  hz_lu_detect #(.REGW(REGW)) u_lu_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .hazard     (lu_hit)
  );

  assign mem_miss = (dREN || dWEN) && !dhit;
  assign state    = state_q;

  always_comb begin
    stage_wen   = '1;
    stage_flush = '0;
    halted      = 1'b0;
    state_d     = RUN;
    lu_d        = lu_q;
    if (RST) begin
      lu_d = '0;
    end else if (state_q == HALTED) begin
      stage_wen = '0;
      halted    = 1'b1;
      state_d   = HALTED;
    end else if (mem_miss) begin
      for (int i = 0; i < NSTAGES; i++) stage_wen[i] = (i >= MEM_IDX);
      stage_flush[MEM_IDX] = 1'b1;
      state_d = DWAIT;
    end else if (halt_req) begin
      for (int i = 0; i < NSTAGES; i++) stage_flush[i] = (i < MEM_IDX);
      state_d = HALTED;
    end else if (redirect) begin
      // loop bound doubles as the clamp for out-of-range stage indices
      for (int i = 0; i < NSTAGES; i++) stage_flush[i] = (i < int'(redirect_stg));
      lu_d = '0;
    end else if (lu_hit || (state_q == LUSTALL)) begin
      stage_wen[IFID]   = 1'b0;
      stage_flush[IDEX] = 1'b1;
      if (state_q == LUSTALL) begin
        lu_d    = lu_q - LUCW'(1);
        state_d = (lu_q == LUCW'(1)) ? RUN : LUSTALL;
      end else begin
        lu_d    = LUCW'(LU_STALL - 1);
        state_d = (LU_STALL > 1) ? LUSTALL : RUN;
      end
    end else if (!ihit) begin
      stage_wen[IFID]   = 1'b0;
      stage_flush[IFID] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RUN;
      lu_q      <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
      if (!stage_wen[IFID] && (state_q != HALTED) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + PCW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_n.sv
// Self-checking bench for hazard_ctrl_n: vector table, directed corner sequences,
// then randomized traffic against a rule-level reference model.
module tb_hazard_ctrl_n;

  logic        CLK, RST, ihit, dhit, dREN, dWEN, redirect, halt_req;
  logic        ex_memread, id_use_rs, id_use_rt;
  logic [2:0]  redirect_stg;
  logic [4:0]  ex_rd, id_rs, id_rt;
  logic [4:0]  stage_wen, stage_flush, wen4, flush4;
  logic        halted, halted4;
  logic [1:0]  state, state4;
  logic [31:0] stall_cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int failures = 0;

  hazard_ctrl_n #(.NSTAGES(5), .MEM_IDX(3), .REGW(5), .LU_STALL(2), .PCW(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .redirect(redirect), .redirect_stg(redirect_stg), .halt_req(halt_req),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .stage_wen(stage_wen), .stage_flush(stage_flush), .halted(halted),
    .state(state), .stall_cnt(stall_cnt));

  hazard_ctrl_n #(.NSTAGES(5), .MEM_IDX(3), .REGW(5), .LU_STALL(2), .PCW(4)) dut4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .redirect(redirect), .redirect_stg(redirect_stg), .halt_req(halt_req),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .stage_wen(wen4), .stage_flush(flush4), .halted(halted4),
    .state(state4), .stall_cnt(cnt4));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; dREN = 1'b0; dWEN = 1'b0; redirect = 1'b0;
    redirect_stg = 3'd0; halt_req = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    idle(); RST = 1'b1; tick(); RST = 1'b0;
  endtask

  // ---------------- reference model (rule level, 5 stages, MEM at 3, 2 bubbles)
  int     m_state;   // 0 RUN, 1 DWAIT, 2 LUSTALL, 3 HALTED
  int     m_left;    // bubbles still owed after the current one
  longint m_cnt;     // unbounded stall-cycle tally

  function automatic bit lu_match();
    return ex_memread && (ex_rd != 0) &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  endfunction

  task automatic model_eval(output logic [4:0] ew, output logic [4:0] ef, output logic eh,
                            output int nxt, output int nleft);
    ew = 5'h1F; ef = 5'h00; eh = 1'b0; nxt = 0; nleft = m_left;
    if (RST) begin
      nleft = 0;
    end else if (m_state == 3) begin
      ew = 5'h00; eh = 1'b1; nxt = 3;
    end else if ((dREN || dWEN) && !dhit) begin
      ew = 5'b11000; ef = 5'b01000; nxt = 1;
    end else if (halt_req) begin
      ef = 5'b00111; nxt = 3;
    end else if (redirect) begin
      int s;
      s = (redirect_stg > 5) ? 5 : int'(redirect_stg);
      ef = 5'((1 << s) - 1); nleft = 0;
    end else if (lu_match() || m_state == 2) begin
      ew = 5'b11110; ef = 5'b00010;
      nleft = (m_state == 2) ? m_left - 1 : 2 - 1;
      nxt = (nleft > 0) ? 2 : 0;
    end else if (!ihit) begin
      ew = 5'b11110; ef = 5'b00001;
    end
  endtask

  task automatic rand_cycle();
    logic [4:0] ew, ef;
    logic eh;
    int nxt, nleft;
    longint sat4, sat32;
    RST        = ($urandom_range(99, 0) < 4);
    ihit       = ($urandom_range(99, 0) < 75);
    dhit       = ($urandom_range(99, 0) < 60);
    dREN       = ($urandom_range(99, 0) < 20);
    dWEN       = ($urandom_range(99, 0) < 10);
    redirect   = ($urandom_range(99, 0) < 12);
    redirect_stg = 3'($urandom_range(7, 0));
    halt_req   = ($urandom_range(99, 0) < 2);
    ex_memread = ($urandom_range(99, 0) < 45);
    ex_rd      = 5'($urandom_range(3, 0));
    id_rs      = 5'($urandom_range(3, 0));
    id_rt      = 5'($urandom_range(3, 0));
    id_use_rs  = ($urandom_range(99, 0) < 70);
    id_use_rt  = ($urandom_range(99, 0) < 50);
    #4;
    model_eval(ew, ef, eh, nxt, nleft);
    sat4  = (m_cnt > 15) ? 15 : m_cnt;
    sat32 = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt;
    chk("rnd_wen", stage_wen, ew);
    chk("rnd_flush", stage_flush, ef);
    chk("rnd_halted", halted, eh);
    chk("rnd_state", state, m_state);
    chk("rnd_cnt", stall_cnt, sat32);
    chk("rnd_cnt4", cnt4, sat4);
    chk("rnd_wen4", wen4, ew);
    @(posedge CLK);
    if (RST) m_cnt = 0;
    else if (m_state != 3 && ew[0] == 1'b0) m_cnt++;
    m_state = nxt;
    m_left  = nleft;
    #1;
  endtask

  // ---------------- vector table (single cycle from RUN)
  typedef struct packed {
    logic ih, dh, drd, dwr, rdr; logic [2:0] stg; logic hlt, mrd;
    logic [4:0] rd, rs, rt; logic urs, urt; logic [4:0] ew, ef;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h1F,5'h00};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h1E,5'h01};
    vt[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,3'd0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h18,5'h08};
    vt[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h1E,5'h01};
    vt[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h1F,5'h07};
    vt[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,3'd0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h1F,5'h00};
    vt[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,3'd4,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h1F,5'h0F};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,3'd7,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h1F,5'h1F};
    vt[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b1,5'd7,5'd2,5'd7,1'b1,1'b1,5'h1E,5'h02};
    vt[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b1,5'd0,5'd0,5'd0,1'b1,1'b1,5'h1F,5'h00};
    vt[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b1,5'd9,5'd9,5'd9,1'b0,1'b0,5'h1F,5'h00};
    vt[11] = '{1'b1,1'b0,1'b1,1'b0,1'b1,3'd4,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h18,5'h08};
    vt[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1,3'd2,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,5'h1F,5'h07};
    vt[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd1,1'b0,1'b1,5'd3,5'd3,5'd0,1'b1,1'b0,5'h1F,5'h01};
  end

  initial begin
    logic [31:0] cnt_snap;
    idle(); RST = 1'b1;
    #1;
    tick(); tick(); RST = 1'b0;
    #4;
    chk("reset_state", state, 2'd0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_cnt", stall_cnt, 32'd0);

    for (int i = 0; i < 14; i++) begin
      do_reset();
      ihit = vt[i].ih; dhit = vt[i].dh; dREN = vt[i].drd; dWEN = vt[i].dwr;
      redirect = vt[i].rdr; redirect_stg = vt[i].stg; halt_req = vt[i].hlt;
      ex_memread = vt[i].mrd; ex_rd = vt[i].rd; id_rs = vt[i].rs; id_rt = vt[i].rt;
      id_use_rs = vt[i].urs; id_use_rt = vt[i].urt;
      #4;
      chk($sformatf("vec%0d_wen", i), stage_wen, vt[i].ew);
      chk($sformatf("vec%0d_flush", i), stage_flush, vt[i].ef);
    end

    // load r5 then add r6 = r5 + r1: two bubbles
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_rt = 5'd1; id_use_rs = 1'b1; id_use_rt = 1'b1;
    #4;
    chk("lu_c1_wen", stage_wen, 5'h1E);
    chk("lu_c1_flush", stage_flush, 5'h02);
    chk("lu_c1_state", state, 2'd0);
    tick(); ex_memread = 1'b0;
    #4;
    chk("lu_c2_state", state, 2'd2);
    chk("lu_c2_wen", stage_wen, 5'h1E);
    chk("lu_c2_flush", stage_flush, 5'h02);
    tick();
    #4;
    chk("lu_c3_state", state, 2'd0);
    chk("lu_c3_wen", stage_wen, 5'h1F);
    chk("lu_cnt", stall_cnt, 32'd2);

    // data read miss for four cycles
    do_reset();
    dREN = 1'b1; dhit = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #4;
      chk($sformatf("dw%0d_wen", c), stage_wen, 5'b11000);
      chk($sformatf("dw%0d_flush", c), stage_flush, 5'b01000);
      tick();
    end
    dhit = 1'b1;
    #4;
    chk("dw_state", state, 2'd1);
    chk("dw_hit_wen", stage_wen, 5'h1F);
    chk("dw_hit_flush", stage_flush, 5'h00);
    tick();
    #4;
    chk("dw_exit_state", state, 2'd0);
    chk("dw_cnt", stall_cnt, 32'd4);

    // redirect beats a concurrent load-use
    do_reset();
    redirect = 1'b1; redirect_stg = 3'd2;
    ex_memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_use_rs = 1'b1;
    #4;
    chk("rd_wen", stage_wen, 5'h1F);
    chk("rd_flush", stage_flush, 5'b00011);
    tick(); idle();
    #4;
    chk("rd_state", state, 2'd0);
    chk("rd_next_wen", stage_wen, 5'h1F);
    chk("rd_cnt", stall_cnt, 32'd0);

    // halt is sticky
    do_reset();
    ihit = 1'b0; tick(); ihit = 1'b1;
    halt_req = 1'b1;
    #4;
    chk("halt_pulse_flush", stage_flush, 5'b00111);
    tick(); halt_req = 1'b0;
    #4;
    chk("halt_halted", halted, 1'b1);
    chk("halt_wen", stage_wen, 5'h00);
    chk("halt_state", state, 2'd3);
    cnt_snap = stall_cnt;
    for (int c = 0; c < 10; c++) begin
      tick();
      ihit = c[0]; redirect = ~c[0]; dREN = c[1]; dhit = 1'b0; redirect_stg = 3'd3;
    end
    #4;
    chk("halt_stay", halted, 1'b1);
    chk("halt_wen_stay", stage_wen, 5'h00);
    chk("halt_cnt_frozen", stall_cnt, cnt_snap);
    chk("halt_cnt_value", stall_cnt, 32'd1);

    // reset in the middle of a data wait
    do_reset();
    dREN = 1'b1; dhit = 1'b0;
    tick(); tick();
    #4;
    chk("rst_dw_pre", state, 2'd1);
    tick();
    RST = 1'b1;
    #4;
    chk("rst_cycle_wen", stage_wen, 5'h1F);
    tick(); RST = 1'b0;
    #4;
    chk("rst_dw_state", state, 2'd0);
    chk("rst_dw_cnt", stall_cnt, 32'd0);
    chk("rst_dw_halted", halted, 1'b0);

    // counter saturation on the 4-bit instance
    do_reset();
    ihit = 1'b0;
    for (int c = 0; c < 19; c++) tick();
    #4;
    chk("sat_cnt4", cnt4, 4'hF);
    chk("sat_cnt32", stall_cnt, 32'd19);

    // randomized traffic against the model
    do_reset();
    m_state = 0; m_left = 0; m_cnt = 0;
    for (int n = 0; n < 800; n++) rand_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
